// File: rtl/wb_commit.sv
// wb_commit: writeback/commit stage.
// Accepts one W-stage bundle over a valid/ready handshake and spends one
// cycle driving the GPR, CSR and trap-state write strobes. It then offers
// the next PC to fetch over a second valid/ready handshake. Only one
// instruction is in flight at a time, so each instruction takes at least
// 3 cycles.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   s_valid / s_ready     bundle handshake from the M->W register
//   dnpcW .. rdW          W-stage bundle fields
//   rf_wen/waddr/wdata    GPR write port (valid only in COMMIT)
//   csr_wen/waddr/wdata   CSR write port (valid only in COMMIT)
//   exc_wen/mepc/mcause   ecall trap-state write (valid only in COMMIT)
//   m_valid / m_ready     next-PC handshake to fetch
//   npc                   next PC presented to fetch
//   retire_cnt            64-bit retired-instruction counter
module wb_commit #(
  parameter logic [31:0] RESET_NPC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] dnpcW,
  input  logic [31:0] snpcW,
  input  logic [31:0] pcW,
  input  logic [2:0]  rdregsrcW,
  input  logic [31:0] mdataW,
  input  logic [31:0] ALU_resultW,
  input  logic [31:0] csrW,
  input  logic [11:0] csraddrW,
  input  logic        cmp_resultW,
  input  logic        ecallW,
  input  logic [4:0]  rdW,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        exc_wen,
  output logic [31:0] exc_mepc,
  output logic [31:0] exc_mcause,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] npc,
  output logic [63:0] retire_cnt
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

  state_t      state, state_next;

  logic [31:0] dnpc_q, snpc_q, pc_q, mdata_q, alu_q, csr_q;
  logic [2:0]  src_q;
  logic [11:0] csraddr_q;
  logic        cmp_q, ecall_q;
  logic [4:0]  rd_q;
  logic [31:0] npc_q;
  logic [63:0] retire_q;

  logic        in_commit;
  logic        sel_valid;
  logic [31:0] sel_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (s_valid) state_next = COMMIT;
      COMMIT:   state_next = REDIRECT;
      REDIRECT: if (m_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // The bundle is captured only on the accepting edge, so upstream may
  // change its outputs freely while the instruction is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dnpc_q    <= '0;
      snpc_q    <= '0;
      pc_q      <= '0;
      mdata_q   <= '0;
      alu_q     <= '0;
      csr_q     <= '0;
      src_q     <= '0;
      csraddr_q <= '0;
      cmp_q     <= 1'b0;
      ecall_q   <= 1'b0;
      rd_q      <= '0;
    end else if (state == IDLE && s_valid) begin
      dnpc_q    <= dnpcW;
      snpc_q    <= snpcW;
      pc_q      <= pcW;
      mdata_q   <= mdataW;
      alu_q     <= ALU_resultW;
      csr_q     <= csrW;
      src_q     <= rdregsrcW;
      csraddr_q <= csraddrW;
      cmp_q     <= cmp_resultW;
      ecall_q   <= ecallW;
      rd_q      <= rdW;
    end
  end

  // The instruction retires and the redirect target is loaded on the edge
  // that leaves COMMIT. A reset before that edge therefore leaves no trace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      npc_q    <= RESET_NPC;
      retire_q <= '0;
    end else if (state == COMMIT) begin
      npc_q    <= dnpc_q;
      retire_q <= retire_q + 64'd1;
    end
  end

  // Select the rd data source. Codes 0, 6 and 7 mean no GPR write.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (src_q)
      3'd1: begin sel_valid = 1'b1; sel_data = alu_q;            end
      3'd2: begin sel_valid = 1'b1; sel_data = mdata_q;          end
      3'd3: begin sel_valid = 1'b1; sel_data = snpc_q;           end
      3'd4: begin sel_valid = 1'b1; sel_data = csr_q;            end
      3'd5: begin sel_valid = 1'b1; sel_data = {31'b0, cmp_q};   end
      default: begin sel_valid = 1'b0; sel_data = '0;            end
    endcase
  end

  assign in_commit  = (state == COMMIT);
  assign s_ready    = (state == IDLE);
  assign m_valid    = (state == REDIRECT);

  // An ecall suppresses the GPR and CSR writes and raises the trap-state
  // write instead. A CSR write ignores rd, so csrrw x0 still updates the CSR.
  assign rf_wen     = in_commit & sel_valid & (rd_q != 5'd0) & ~ecall_q;
  assign rf_waddr   = rd_q;
  assign rf_wdata   = sel_data;
  assign csr_wen    = in_commit & (src_q == 3'd4) & ~ecall_q;
  assign csr_waddr  = csraddr_q;
  assign csr_wdata  = alu_q;
  assign exc_wen    = in_commit & ecall_q;
  assign exc_mepc   = pc_q;
  assign exc_mcause = 32'd11;

  assign npc        = npc_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: self-checking bench for wb_commit.
// It compares the DUT against a behavioural model of the commit rules:
// rd source selection, ecall suppression, the retire counter and the
// handshake timing.
module tb_wb_commit;

  logic        clk, rst, s_valid, s_ready, m_valid, m_ready;
  logic [31:0] dnpcW, snpcW, pcW, mdataW, ALU_resultW, csrW;
  logic [2:0]  rdregsrcW;
  logic [11:0] csraddrW;
  logic        cmp_resultW, ecallW;
  logic [4:0]  rdW;
  logic        rf_wen, csr_wen, exc_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wdata, exc_mepc, exc_mcause, npc;
  logic [11:0] csr_waddr;
  logic [63:0] retire_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  longint unsigned exp_cnt = 0;

  typedef struct {
    logic [31:0] dnpc, snpc, pc, mdata, alu, csr;
    logic [2:0]  src;
    logic [11:0] csraddr;
    logic        cmp, ecall;
    logic [4:0]  rd;
  } bundle_t;

  // Values observed during one instruction
  logic        o_rf_wen, o_csr_wen, o_exc_wen, o_sready_c, o_mvalid_c;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata, o_csr_wdata, o_mepc, o_mcause, o_npc;
  logic [11:0] o_csr_waddr;
  logic        o_mvalid, o_sready_r, o_sready_after, o_mvalid_after;
  logic        o_stable, o_timeout;
  logic [63:0] o_cnt;

  wb_commit #(.RESET_NPC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .dnpcW(dnpcW), .snpcW(snpcW), .pcW(pcW), .rdregsrcW(rdregsrcW),
    .mdataW(mdataW), .ALU_resultW(ALU_resultW), .csrW(csrW),
    .csraddrW(csraddrW), .cmp_resultW(cmp_resultW), .ecallW(ecallW),
    .rdW(rdW), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .exc_wen(exc_wen), .exc_mepc(exc_mepc), .exc_mcause(exc_mcause),
    .m_valid(m_valid), .m_ready(m_ready), .npc(npc), .retire_cnt(retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: GPR write rule and data
  function automatic logic exp_rf_wen(input bundle_t b);
    return !b.ecall && b.rd != 5'd0 && b.src >= 3'd1 && b.src <= 3'd5;
  endfunction

  function automatic logic [31:0] exp_rf_wdata(input bundle_t b);
    case (b.src)
      3'd1: return b.alu;
      3'd2: return b.mdata;
      3'd3: return b.snpc;
      3'd4: return b.csr;
      3'd5: return b.cmp ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_csr_wen(input bundle_t b);
    return !b.ecall && b.src == 3'd4;
  endfunction

  function automatic bundle_t zero_bundle();
    bundle_t b;
    b.dnpc = 0; b.snpc = 0; b.pc = 0; b.mdata = 0; b.alu = 0; b.csr = 0;
    b.src = 0; b.csraddr = 0; b.cmp = 0; b.ecall = 0; b.rd = 0;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.dnpc = $urandom; b.snpc = $urandom; b.pc = $urandom;
    b.mdata = $urandom; b.alu = $urandom; b.csr = $urandom;
    b.src = 3'($urandom_range(0, 7));
    b.csraddr = 12'($urandom);
    b.cmp = 1'($urandom);
    b.ecall = ($urandom_range(0, 3) == 0);
    b.rd = 5'($urandom);
    return b;
  endfunction

  task automatic apply_bundle(input bundle_t b);
    dnpcW = b.dnpc; snpcW = b.snpc; pcW = b.pc; mdataW = b.mdata;
    ALU_resultW = b.alu; csrW = b.csr; rdregsrcW = b.src;
    csraddrW = b.csraddr; cmp_resultW = b.cmp; ecallW = b.ecall; rdW = b.rd;
  endtask

  // Drive one instruction through accept, commit, redirect (with `delay`
  // cycles of fetch backpressure) and handshake. Observations are recorded
  // for the calling test. The bundle inputs are scrambled after acceptance.
  task automatic run_instr(input bundle_t b, input int delay);
    int n;
    o_timeout = 1'b0;
    o_stable  = 1'b1;
    @(negedge clk);
    n = 0;
    while (s_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) o_timeout = 1'b1;
    apply_bundle(b);
    s_valid = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    o_rf_wen = rf_wen; o_rf_waddr = rf_waddr; o_rf_wdata = rf_wdata;
    o_csr_wen = csr_wen; o_csr_waddr = csr_waddr; o_csr_wdata = csr_wdata;
    o_exc_wen = exc_wen; o_mepc = exc_mepc; o_mcause = exc_mcause;
    o_sready_c = s_ready; o_mvalid_c = m_valid;
    apply_bundle(rand_bundle());
    @(negedge clk);
    o_mvalid = m_valid; o_npc = npc; o_cnt = retire_cnt; o_sready_r = s_ready;
    if (rf_wen | csr_wen | exc_wen) o_stable = 1'b0;
    for (int i = 0; i < delay; i++) begin
      apply_bundle(rand_bundle());
      @(negedge clk);
      if (npc !== o_npc || m_valid !== 1'b1 || s_ready !== 1'b0 ||
          (rf_wen | csr_wen | exc_wen) !== 1'b0 || retire_cnt !== o_cnt)
        o_stable = 1'b0;
    end
    m_ready = 1'b1;
    @(negedge clk);
    o_sready_after = s_ready;
    o_mvalid_after = m_valid;
    s_valid = 1'b0;
    m_ready = 1'b0;
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    apply_bundle(rand_bundle());
    s_valid = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_s_ready got %b want 1", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
    n_checks++; if ({rf_wen, csr_wen, exc_wen} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_strobes got %b want 000", {rf_wen, csr_wen, exc_wen}); end
    n_checks++; if (npc !== 32'h8000_0000) begin n_fail++; $display("[TB] FAIL reset_npc got %h want 80000000", npc); end
    n_checks++; if (retire_cnt !== 64'd0) begin n_fail++; $display("[TB] FAIL reset_cnt got %0d want 0", retire_cnt); end
    n_checks++; if (rf_waddr !== 5'd0 || csr_waddr !== 12'd0 || exc_mepc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_latched got %h/%h/%h want 0", rf_waddr, csr_waddr, exc_mepc); end
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle got s_ready=%b m_valid=%b want 1/0", s_ready, m_valid); end
  endtask

  task automatic test_alu();
    bundle_t b = zero_bundle();
    b.src = 3'd1; b.rd = 5'd5; b.alu = 32'h1234; b.dnpc = 32'h8000_0004;
    run_instr(b, 0);
    n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_timeout got %b want 0", o_timeout); end
    n_checks++; if (o_rf_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_rf_wen got %b want 1", o_rf_wen); end
    n_checks++; if (o_rf_waddr !== 5'd5) begin n_fail++; $display("[TB] FAIL alu_rf_waddr got %0d want 5", o_rf_waddr); end
    n_checks++; if (o_rf_wdata !== 32'h1234) begin n_fail++; $display("[TB] FAIL alu_rf_wdata got %h want 1234", o_rf_wdata); end
    n_checks++; if (o_mvalid_c !== 1'b0 || o_sready_c !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_commit_hs got m_valid=%b s_ready=%b want 0/0", o_mvalid_c, o_sready_c); end
    n_checks++; if (o_mvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_m_valid got %b want 1", o_mvalid); end
    n_checks++; if (o_npc !== 32'h8000_0004) begin n_fail++; $display("[TB] FAIL alu_npc got %h want 80000004", o_npc); end
    n_checks++; if (o_cnt !== 64'd1) begin n_fail++; $display("[TB] FAIL alu_cnt got %0d want 1", o_cnt); end
    n_checks++; if (o_sready_after !== 1'b1 || o_mvalid_after !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_return got s_ready=%b m_valid=%b want 1/0", o_sready_after, o_mvalid_after); end
  endtask

  task automatic test_sources();
    bundle_t b;
    for (int i = 0; i < 3; i++) begin
      b = rand_bundle();
      b.ecall = 1'b0;
      case (i)
        0: begin b.src = 3'd2; b.rd = 5'd0; end
        1: begin b.src = 3'd5; b.cmp = 1'b1; b.rd = 5'd3; end
        default: begin b.src = 3'd7; b.rd = 5'd9; end
      endcase
      run_instr(b, 1);
      n_checks++; if (o_rf_wen !== exp_rf_wen(b)) begin n_fail++; $display("[TB] FAIL src%0d_rf_wen got %b want %b", i, o_rf_wen, exp_rf_wen(b)); end
      if (exp_rf_wen(b)) begin
        n_checks++; if (o_rf_wdata !== exp_rf_wdata(b)) begin n_fail++; $display("[TB] FAIL src%0d_rf_wdata got %h want %h", i, o_rf_wdata, exp_rf_wdata(b)); end
      end
      n_checks++; if (o_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL src%0d_cnt got %0d want %0d", i, o_cnt, exp_cnt); end
    end
  endtask

  task automatic test_csr_ecall();
    bundle_t b = zero_bundle();
    b.src = 3'd4; b.csraddr = 12'h305; b.csr = 32'hA; b.alu = 32'hB; b.rd = 5'd2;
    b.dnpc = 32'h8000_0010;
    run_instr(b, 0);
    n_checks++; if (o_rf_wen !== 1'b1 || o_rf_wdata !== 32'hA) begin n_fail++; $display("[TB] FAIL csr_rf got wen=%b data=%h want 1/a", o_rf_wen, o_rf_wdata); end
    n_checks++; if (o_csr_wen !== 1'b1 || o_csr_waddr !== 12'h305 || o_csr_wdata !== 32'hB) begin n_fail++; $display("[TB] FAIL csr_write got %b/%h/%h want 1/305/b", o_csr_wen, o_csr_waddr, o_csr_wdata); end
    n_checks++; if (o_exc_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL csr_exc_wen got %b want 0", o_exc_wen); end
    b.ecall = 1'b1; b.pc = 32'h8000_0100; b.dnpc = 32'h8000_0200;
    run_instr(b, 0);
    n_checks++; if (o_exc_wen !== 1'b1 || o_mepc !== 32'h8000_0100 || o_mcause !== 32'd11) begin n_fail++; $display("[TB] FAIL ecall_exc got %b/%h/%0d want 1/80000100/11", o_exc_wen, o_mepc, o_mcause); end
    n_checks++; if (o_rf_wen !== 1'b0 || o_csr_wen !== 1'b0) begin n_fail++; $display("[TB] FAIL ecall_suppress got rf=%b csr=%b want 0/0", o_rf_wen, o_csr_wen); end
    n_checks++; if (o_npc !== 32'h8000_0200) begin n_fail++; $display("[TB] FAIL ecall_npc got %h want 80000200", o_npc); end
  endtask

  task automatic test_backpressure();
    bundle_t b = rand_bundle();
    run_instr(b, 5);
    n_checks++; if (o_stable !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_stable got %b want 1", o_stable); end
    n_checks++; if (o_sready_r !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_s_ready got %b want 0", o_sready_r); end
    n_checks++; if (o_npc !== b.dnpc) begin n_fail++; $display("[TB] FAIL bp_npc got %h want %h", o_npc, b.dnpc); end
    n_checks++; if (retire_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL bp_cnt got %0d want %0d", retire_cnt, exp_cnt); end
  endtask

  task automatic test_random();
    bundle_t b;
    for (int i = 0; i < 40; i++) begin
      b = rand_bundle();
      run_instr(b, $urandom_range(0, 3));
      n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d_timeout got %b want 0", i, o_timeout); end
      n_checks++; if (o_rf_wen !== exp_rf_wen(b)) begin n_fail++; $display("[TB] FAIL rnd%0d_rf_wen got %b want %b", i, o_rf_wen, exp_rf_wen(b)); end
      if (exp_rf_wen(b)) begin
        n_checks++; if (o_rf_waddr !== b.rd || o_rf_wdata !== exp_rf_wdata(b)) begin n_fail++; $display("[TB] FAIL rnd%0d_rf got %0d/%h want %0d/%h", i, o_rf_waddr, o_rf_wdata, b.rd, exp_rf_wdata(b)); end
      end
      n_checks++; if (o_csr_wen !== exp_csr_wen(b)) begin n_fail++; $display("[TB] FAIL rnd%0d_csr_wen got %b want %b", i, o_csr_wen, exp_csr_wen(b)); end
      if (exp_csr_wen(b)) begin
        n_checks++; if (o_csr_waddr !== b.csraddr || o_csr_wdata !== b.alu) begin n_fail++; $display("[TB] FAIL rnd%0d_csr got %h/%h want %h/%h", i, o_csr_waddr, o_csr_wdata, b.csraddr, b.alu); end
      end
      n_checks++; if (o_exc_wen !== b.ecall) begin n_fail++; $display("[TB] FAIL rnd%0d_exc_wen got %b want %b", i, o_exc_wen, b.ecall); end
      if (b.ecall) begin
        n_checks++; if (o_mepc !== b.pc || o_mcause !== 32'd11) begin n_fail++; $display("[TB] FAIL rnd%0d_exc got %h/%0d want %h/11", i, o_mepc, o_mcause, b.pc); end
      end
      n_checks++; if (o_mvalid !== 1'b1 || o_npc !== b.dnpc) begin n_fail++; $display("[TB] FAIL rnd%0d_redirect got %b/%h want 1/%h", i, o_mvalid, o_npc, b.dnpc); end
      n_checks++; if (o_cnt !== exp_cnt || o_stable !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd%0d_cnt got %0d stable=%b want %0d stable=1", i, o_cnt, o_stable, exp_cnt); end
      n_checks++; if (o_sready_after !== 1'b1) begin n_fail++; $display("[TB] FAIL rnd%0d_return got %b want 1", i, o_sready_after); end
    end
  endtask

  task automatic test_reset_mid();
    bundle_t b = zero_bundle();
    b.src = 3'd1; b.rd = 5'd7; b.alu = 32'hDEAD; b.dnpc = 32'h1234_5678;
    // Reset while in COMMIT
    @(negedge clk);
    apply_bundle(b);
    s_valid = 1'b1;
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("[TB] FAIL midc_pre got %b want 1", rf_wen); end
    rst = 1'b0;
    #1;
    n_checks++; if (rf_wen !== 1'b0 || s_ready !== 1'b1 || retire_cnt !== 64'd0) begin n_fail++; $display("[TB] FAIL midc_abort got wen=%b s_ready=%b cnt=%0d want 0/1/0", rf_wen, s_ready, retire_cnt); end
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    // Reset while in REDIRECT
    @(negedge clk);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(posedge clk);
    #2;
    n_checks++; if (m_valid !== 1'b1 || npc !== 32'h1234_5678) begin n_fail++; $display("[TB] FAIL midr_pre got %b/%h want 1/12345678", m_valid, npc); end
    rst = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || npc !== 32'h8000_0000 || retire_cnt !== 64'd0) begin n_fail++; $display("[TB] FAIL midr_abort got %b/%h/%0d want 0/80000000/0", m_valid, npc, retire_cnt); end
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_wrap();
    bundle_t b;
    // Carry from the low word into the high word
    @(negedge clk);
    force dut.retire_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.retire_q;
    exp_cnt = 64'h0000_0000_FFFF_FFFF;
    b = rand_bundle();
    run_instr(b, 0);
    n_checks++; if (retire_cnt !== 64'h0000_0001_0000_0000) begin n_fail++; $display("[TB] FAIL carry_cnt got %h want 0000000100000000", retire_cnt); end
    // Full 64-bit wrap
    @(negedge clk);
    force dut.retire_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_q;
    exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    b = rand_bundle();
    run_instr(b, 0);
    n_checks++; if (retire_cnt !== 64'(exp_cnt) || retire_cnt !== 64'd0) begin n_fail++; $display("[TB] FAIL wrap_cnt got %h want 0", retire_cnt); end
  endtask

  initial begin
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    apply_bundle(zero_bundle());
    test_reset();
    test_alu();
    test_sources();
    test_csr_ecall();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
